// File: rtl/scarv_soc_bram_initiator.sv
// Bridges the SCARV SoC request/response memory bus onto a single-port BRAM.
// One response register stage; back-to-back accesses stream at one per cycle.
module scarv_soc_bram_initiator #(
  parameter int unsigned WRITE_EN  = 1,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int unsigned LW       = $clog2(DEPTH)
) (
  input  logic          clka,
  input  logic          rsta,

  input  logic          mem_req,
  output logic          mem_gnt,
  input  logic          mem_wen,
  input  logic [3:0]    mem_strb,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,

  output logic          mem_recv,
  input  logic          mem_ack,
  output logic          mem_error,
  output logic [31:0]   mem_rdata,

  output logic          ena,
  output logic [3:0]    wea,
  output logic [LW-1:0] addra,
  output logic [31:0]   dina,
  input  logic [31:0]   douta
);

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_t;

  state_t state;
  logic   rsp_pending;
  logic   rsp_err;
  logic   rsp_wen;
  logic   in_range;
  logic   bad;

  assign rsp_pending = (state == RSP);

  // BASE_ADDR is DEPTH-aligned, so the window test reduces to the upper bits.
  assign in_range = (mem_addr[31:LW] == BASE_ADDR[31:LW]);

  always_comb begin
    bad = 1'b0;
    if (!in_range)                      bad = 1'b1;
    if (mem_addr[1:0] != 2'b00)         bad = 1'b1;
    if (mem_wen && (WRITE_EN == 0))     bad = 1'b1;
  end

  assign mem_gnt = mem_req && (!rsp_pending || mem_ack) && !rsta;

  assign ena   = mem_gnt && !bad;
  assign wea   = (mem_wen && ena) ? mem_strb : 4'b0000;
  assign addra = mem_addr[LW-1:0] - BASE_ADDR[LW-1:0];
  assign dina  = mem_wdata;

  assign mem_recv  = rsp_pending;
  assign mem_error = rsp_pending && rsp_err;
  // douta only changes on an enabled edge, so it is safe to pass straight through
  // while a response is stalled waiting for mem_ack.
  assign mem_rdata = (rsp_pending && !rsp_err && !rsp_wen) ? douta : '0;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state   <= IDLE;
      rsp_err <= 1'b0;
      rsp_wen <= 1'b0;
    end else if (mem_gnt) begin
      state   <= RSP;
      rsp_err <= bad;
      rsp_wen <= mem_wen;
    end else if (rsp_pending && mem_ack) begin
      state   <= IDLE;
    end
  end

endmodule

// File: tb/tb_scarv_soc_bram_initiator.sv
// Self-checking bench: a RAM instance (base 0) and a ROM instance (base 0x1000)
// share one stimulus stream; a transaction-level model checks both every cycle.
module tb_scarv_soc_bram_initiator;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        mem_req = 1'b0, mem_wen = 1'b0, mem_ack = 1'b0;
  logic [3:0]  mem_strb = '0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;

  logic        gnt0, recv0, err0, ena0;
  logic [31:0] rdata0, dina0;
  logic [31:0] douta0 = '0;
  logic [3:0]  wea0;
  logic [9:0]  addra0;

  logic        gnt1, recv1, err1, ena1;
  logic [31:0] rdata1, dina1;
  logic [31:0] douta1 = '0;
  logic [3:0]  wea1;
  logic [7:0]  addra1;

  int tests = 0;
  int fails = 0;

  always #5 clka = ~clka;

  scarv_soc_bram_initiator #(.WRITE_EN(1), .DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clka(clka), .rsta(rsta), .mem_req(mem_req), .mem_gnt(gnt0), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(recv0),
    .mem_ack(mem_ack), .mem_error(err0), .mem_rdata(rdata0), .ena(ena0), .wea(wea0),
    .addra(addra0), .dina(dina0), .douta(douta0));

  scarv_soc_bram_initiator #(.WRITE_EN(0), .DEPTH(256), .BASE_ADDR(32'h0000_1000)) dut1 (
    .clka(clka), .rsta(rsta), .mem_req(mem_req), .mem_gnt(gnt1), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(recv1),
    .mem_ack(mem_ack), .mem_error(err1), .mem_rdata(rdata1), .ena(ena1), .wea(wea1),
    .addra(addra1), .dina(dina1), .douta(douta1));

  function automatic logic [31:0] init_word(int k, int i);
    if (k == 0 && i == 4) return 32'hDEADBEEF;
    return 32'h1357_0000 ^ {8'(k), 8'h5A, 16'(i)};
  endfunction

  // BRAM behaviour: synchronous read, byte-enable write, douta held when idle
  logic        loaded = 1'b0;
  logic [31:0] bram0 [256];
  logic [31:0] bram1 [64];
  always @(posedge clka) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) bram0[i] <= init_word(0, i);
      for (int i = 0; i < 64; i++)  bram1[i] <= init_word(1, i);
      loaded <= 1'b1;
    end else begin
      if (ena0) begin
        douta0 <= bram0[addra0[9:2]];
        for (int b = 0; b < 4; b++)
          if (wea0[b]) bram0[addra0[9:2]][8*b +: 8] <= dina0[8*b +: 8];
      end
      if (ena1) begin
        douta1 <= bram1[addra1[7:2]];
        for (int b = 0; b < 4; b++)
          if (wea1[b]) bram1[addra1[7:2]][8*b +: 8] <= dina1[8*b +: 8];
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: at most one outstanding response per instance
  logic        m_pend [2];
  logic        m_err  [2];
  logic        m_wen  [2];
  logic [31:0] m_data [2];
  logic [31:0] shadow [2][256];

  task automatic model_step(int k);
    logic [31:0] base  = (k == 0) ? 32'h0000_0000 : 32'h0000_1000;
    logic [31:0] depth = (k == 0) ? 32'd1024 : 32'd256;
    logic        we    = (k == 0);
    logic [31:0] off   = mem_addr - base;
    logic        in_rng = (mem_addr >= base) && (mem_addr < base + depth);
    logic        bad   = !in_rng || (mem_addr[1:0] != 2'b00) || (mem_wen && !we);
    logic        e_gnt = mem_req && (!m_pend[k] || mem_ack) && !rsta;
    logic        e_ena = e_gnt && !bad;
    logic        live  = m_pend[k] && !rsta;
    logic [31:0] a_gnt, a_ena, a_wea, a_addra, a_dina, a_recv, a_err, a_rdata;
    if (k == 0) begin
      a_gnt = {31'b0, gnt0};  a_ena = {31'b0, ena0}; a_wea = {28'b0, wea0};
      a_addra = {22'b0, addra0}; a_dina = dina0; a_recv = {31'b0, recv0};
      a_err = {31'b0, err0};  a_rdata = rdata0;
    end else begin
      a_gnt = {31'b0, gnt1};  a_ena = {31'b0, ena1}; a_wea = {28'b0, wea1};
      a_addra = {24'b0, addra1}; a_dina = dina1; a_recv = {31'b0, recv1};
      a_err = {31'b0, err1};  a_rdata = rdata1;
    end
    chk($sformatf("gnt[%0d]", k),   a_gnt,   {31'b0, e_gnt});
    chk($sformatf("ena[%0d]", k),   a_ena,   {31'b0, e_ena});
    chk($sformatf("wea[%0d]", k),   a_wea,   (e_ena && mem_wen) ? {28'b0, mem_strb} : 32'h0);
    chk($sformatf("addra[%0d]", k), a_addra, off & (depth - 32'd1));
    chk($sformatf("dina[%0d]", k),  a_dina,  mem_wdata);
    chk($sformatf("recv[%0d]", k),  a_recv,  {31'b0, live});
    chk($sformatf("err[%0d]", k),   a_err,   {31'b0, live && m_err[k]});
    chk($sformatf("rdata[%0d]", k), a_rdata, (live && !m_err[k] && !m_wen[k]) ? m_data[k] : 32'h0);
    if (rsta) begin
      m_pend[k] = 1'b0;
    end else if (e_gnt) begin
      m_pend[k] = 1'b1;
      m_err[k]  = bad;
      m_wen[k]  = mem_wen;
      m_data[k] = (!bad && !mem_wen) ? shadow[k][off[9:2]] : 32'h0;
      if (!bad && mem_wen)
        for (int b = 0; b < 4; b++)
          if (mem_strb[b]) shadow[k][off[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end else if (m_pend[k] && mem_ack) begin
      m_pend[k] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; m_err[k] = 1'b0; m_wen[k] = 1'b0; m_data[k] = '0;
      for (int i = 0; i < 256; i++) shadow[k][i] = init_word(k, i);
    end
    forever begin
      @(negedge clka);
      model_step(0);
      model_step(1);
    end
  end

  task automatic set_in(logic req, logic wen, logic [3:0] strb, logic [31:0] addr,
                        logic [31:0] wdata, logic ack);
    mem_req = req; mem_wen = wen; mem_strb = strb;
    mem_addr = addr; mem_wdata = wdata; mem_ack = ack;
  endtask

  task automatic next_cycle();
    @(posedge clka);
    #1;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clka);
    #1;
    @(negedge clka);
    chk("rst_gnt", {31'b0, gnt0}, 32'h0);
    chk("rst_recv", {31'b0, recv0}, 32'h0);
    chk("rst_ena", {31'b0, ena0}, 32'h0);
    chk("rst_rdata", rdata0, 32'h0);
    next_cycle();
    rsta = 1'b0;
    next_cycle();

    // single read
    set_in(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
    @(negedge clka);
    chk("rd_ena", {31'b0, ena0}, 32'h1);
    chk("rd_addra", {22'b0, addra0}, 32'h10);
    next_cycle();
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clka);
    chk("rd_recv", {31'b0, recv0}, 32'h1);
    chk("rd_rdata", rdata0, 32'hDEADBEEF);
    chk("rd_err", {31'b0, err0}, 32'h0);
    next_cycle();

    // partial write then read back
    set_in(1'b1, 1'b1, 4'b0101, 32'h8, 32'h11223344, 1'b1);
    @(negedge clka);
    chk("wr_wea", {28'b0, wea0}, 32'h5);
    chk("wr_dina", dina0, 32'h11223344);
    next_cycle();
    set_in(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1);
    @(negedge clka);
    chk("wr_rsp_rdata", rdata0, 32'h0);
    chk("wr_rsp_recv", {31'b0, recv0}, 32'h1);
    next_cycle();
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clka);
    chk("wr_readback", rdata0, 32'h13220044);
    next_cycle();

    // out of range and misaligned reads
    set_in(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 1'b1);
    @(negedge clka);
    chk("oor_ena", {31'b0, ena0}, 32'h0);
    next_cycle();
    set_in(1'b1, 1'b0, 4'h0, 32'h2, 32'h0, 1'b1);
    @(negedge clka);
    chk("oor_err", {31'b0, err0}, 32'h1);
    chk("mis_ena", {31'b0, ena0}, 32'h0);
    next_cycle();
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clka);
    chk("mis_err", {31'b0, err0}, 32'h1);
    next_cycle();

    // ROM: write rejected, read at offset base
    set_in(1'b1, 1'b1, 4'hF, 32'h1008, 32'hCAFEF00D, 1'b1);
    @(negedge clka);
    chk("rom_wr_ena", {31'b0, ena1}, 32'h0);
    next_cycle();
    set_in(1'b1, 1'b0, 4'h0, 32'h1004, 32'h0, 1'b1);
    @(negedge clka);
    chk("rom_wr_err", {31'b0, err1}, 32'h1);
    chk("rom_rd_addra", {24'b0, addra1}, 32'h4);
    next_cycle();
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clka);
    chk("rom_rd_rdata", rdata1, 32'h120D0001);
    next_cycle();

    // zero-strobe write is a legal no-op access
    set_in(1'b1, 1'b1, 4'h0, 32'hC, 32'hFFFFFFFF, 1'b1);
    @(negedge clka);
    chk("nostrb_ena", {31'b0, ena0}, 32'h1);
    chk("nostrb_wea", {28'b0, wea0}, 32'h0);
    next_cycle();
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clka);
    chk("nostrb_err", {31'b0, err0}, 32'h0);
    next_cycle();

    // backpressure: response held three cycles
    set_in(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    @(negedge clka);
    chk("bp_first_gnt", {31'b0, gnt0}, 32'h1);
    next_cycle();
    set_in(1'b1, 1'b0, 4'h0, 32'h24, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clka);
      chk("bp_gnt", {31'b0, gnt0}, 32'h0);
      chk("bp_ena", {31'b0, ena0}, 32'h0);
      chk("bp_rdata", rdata0, 32'h130D0008);
      next_cycle();
    end
    mem_ack = 1'b1;
    @(negedge clka);
    chk("bp_release_gnt", {31'b0, gnt0}, 32'h1);
    next_cycle();
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clka);
    chk("bp_second_rdata", rdata0, 32'h130D0009);
    next_cycle();

    // streaming: four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 4'h0, 32'h30 + 32'(4 * i), 32'h0, 1'b1);
      @(negedge clka);
      chk("stream_gnt", {31'b0, gnt0}, 32'h1);
      if (i > 0) chk("stream_rdata", rdata0, init_word(0, 11 + i));
      next_cycle();
    end
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clka);
    chk("stream_last_rdata", rdata0, init_word(0, 15));
    next_cycle();

    // asynchronous reset while a response is pending
    set_in(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1);
    @(posedge clka);
    #1;
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_recv", {31'b0, recv0}, 32'h1);
    #1 rsta = 1'b1;
    #1;
    chk("async_rst_recv", {31'b0, recv0}, 32'h0);
    @(negedge clka);
    next_cycle();
    rsta = 1'b0;
    set_in(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b1);
    @(negedge clka);
    chk("post_rst_gnt", {31'b0, gnt0}, 32'h1);
    chk("post_rst_no_stale", {31'b0, recv0}, 32'h0);
    next_cycle();
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clka);
    chk("post_rst_rdata", rdata0, init_word(0, 17));
    next_cycle();
    repeat (2) next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scarv_soc_bram_initiator.md
SCARV_SOC_BRAM_INITIATOR -- requirements
Module: scarv_soc_bram_initiator

Interface
REQ-001 SHALL have parameter WRITE_EN, default 1: 1 means writes are permitted; 0 means ROM, and writes are rejected.
REQ-002 SHALL have parameter DEPTH, default 1024: size of the BRAM window in bytes, a power of two.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of BRAM location 0, aligned to DEPTH.
REQ-004 SHALL have localparam LW = $clog2(DEPTH).
REQ-005 SHALL have port clka, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rsta, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port mem_req, input, 1: request valid.
REQ-008 SHALL have port mem_gnt, output, 1: request accepted this cycle.
REQ-009 SHALL have port mem_wen, input, 1: 1 means write, 0 means read.
REQ-010 SHALL have port mem_strb, input, 4: byte write strobes.
REQ-011 SHALL have port mem_addr, input, 32: byte address.
REQ-012 SHALL have port mem_wdata, input, 32: write data.
REQ-013 SHALL have port mem_recv, output, 1: response valid.
REQ-014 SHALL have port mem_ack, input, 1: response accepted by the requester.
REQ-015 SHALL have port mem_error, output, 1: the response is an error.
REQ-016 SHALL have port mem_rdata, output, 32: response read data.
REQ-017 SHALL have port ena, output, 1: BRAM port enable.
REQ-018 SHALL have port wea, output, 4: BRAM byte write enables.
REQ-019 SHALL have port addra, output, LW: BRAM byte address.
REQ-020 SHALL have port dina, output, 32: BRAM write data.
REQ-021 SHALL have port douta, input, 32: BRAM read data, valid 1 cycle after ena and held stable while ena=0.

Function
REQ-022 SHALL keep one outstanding-response state bit, rsp_pending; state IDLE when rsp_pending=0, RSP when rsp_pending=1.
REQ-023 SHALL drive mem_gnt = mem_req && (!rsp_pending || mem_ack) && !rsta.
REQ-024 SHALL flag a request as bad when mem_addr lies outside [BASE_ADDR, BASE_ADDR+DEPTH), or mem_addr[1:0] != 0, or (mem_wen && WRITE_EN == 0).
REQ-025 SHALL drive ena = mem_gnt && !bad; a bad request SHALL never touch the BRAM.
REQ-026 SHALL drive addra = (mem_addr - BASE_ADDR)[LW-1:0], dina = mem_wdata, and wea = (mem_wen && ena) ? mem_strb : 4'b0000.
REQ-027 SHALL handle a write with mem_strb == 0 as a legal no-op access: ena=1, wea=0, normal response.
REQ-028 SHALL, on the rising edge where mem_gnt=1, set rsp_pending=1 and register rsp_err=bad and rsp_wen=mem_wen.
REQ-029 SHALL, on an edge where mem_recv && mem_ack && !mem_gnt, clear rsp_pending (RSP to IDLE).
REQ-030 SHALL, when mem_ack and a new mem_gnt occur in the same cycle, stay in RSP and load the new request's flags, giving back-to-back throughput of 1 request per cycle.
REQ-031 SHALL drive mem_recv = rsp_pending and mem_error = rsp_pending && rsp_err.
REQ-032 SHALL drive mem_rdata = douta when mem_recv && !rsp_err && !rsp_wen, and 32'h0 otherwise.
REQ-033 SHALL give a latency of exactly 1 cycle from the grant edge to mem_recv=1.
REQ-034 SHALL, while mem_recv=1 and mem_ack=0, hold mem_recv, mem_error and mem_rdata stable with ena=0; no skid buffer is needed because douta is stable while ena=0.
REQ-035 SHALL hold every output constant for at most 1 cycle per request; mem_gnt SHALL never assert while a response is pending and not being acked.

Reset
REQ-036 SHALL, while rsta=1, asynchronously force rsp_pending=0, rsp_err=0 and rsp_wen=0, giving mem_recv=0, mem_error=0, mem_rdata=0, mem_gnt=0, ena=0 and wea=0.
REQ-037 SHALL, when rsta asserts mid-operation, discard any pending response without ever delivering it; the first grant is possible in the first cycle after rsta deasserts.

Verification
REQ-038 Read, BASE_ADDR=0: read addr 0x10, douta=0xDEADBEEF in the following cycle, mem_ack=1 -> ena=1, addra=0x10 in cycle 0; mem_recv=1, mem_rdata=0xDEADBEEF, mem_error=0 in cycle 1.
REQ-039 Write: addr 0x8, strb=4'b0101, wdata=0x11223344 -> wea=4'b0101, dina=0x11223344; next cycle mem_recv=1, mem_rdata=0, mem_error=0.
REQ-040 Errors, each with ena=0 and mem_error=1 on the response: read at addr 0x400 with DEPTH=1024; read at addr 0x2 (misaligned); write with WRITE_EN=0.
REQ-041 Backpressure: mem_ack=0 for 3 cycles with mem_req held -> mem_gnt=0, ena=0, mem_rdata stable for all 3 cycles; after mem_ack=1 the next request is granted in the same cycle.
REQ-042 Streaming: 4 back-to-back reads with mem_ack held at 1 -> 4 grants and 4 responses on consecutive cycles, in order.
REQ-043 Reset: rsta pulsed while mem_recv=1 -> mem_recv=0 immediately (asynchronously); no stale response after rsta deasserts.
